// File: rtl/phy_types_pkg.sv
// Shared 8b/10b receive-side types: frame length select, symbol width,
// and the comma / start-of-frame code groups in both running disparities.
package phy_types_pkg;

  localparam int SYM_W            = 10;
  localparam int DEF_SYM_PER_FLIT = 4;

  typedef enum logic {
    LONG  = 1'b0,
    SHORT = 1'b1
  } comma_length_sel_t;

  typedef logic [SYM_W-1:0]                  sym_t;
  typedef logic [DEF_SYM_PER_FLIT*SYM_W-1:0] flit_enc_t;

  // Code groups written abcdeifghj, bit 'a' in the MSB position.
  localparam sym_t K28_5_RDN = 10'b0011111010;
  localparam sym_t K28_5_RDP = 10'b1100000101;
  localparam sym_t K28_0_RDN = 10'b0011110100;
  localparam sym_t K28_0_RDP = 10'b1100001011;
  localparam sym_t K28_2_RDN = 10'b0011110101;
  localparam sym_t K28_2_RDP = 10'b1100001010;

  // True when the window equals either disparity form of a code group.
  function automatic logic sym_is(input sym_t win, input sym_t rdn, input sym_t rdp);
    return (win == rdn) || (win == rdp);
  endfunction

endpackage

// File: rtl/rx_sym_match_8b_10b.sv
// Combinational classifier for the 10-bit receive window: align comma
// (K28.5), long start-of-frame (K28.0) and short start-of-frame (K28.2).
module rx_sym_match_8b_10b
  import phy_types_pkg::*;
(
  input  logic [SYM_W-1:0] i_win,
  output logic             o_is_align,
  output logic             o_is_sof_long,
  output logic             o_is_sof_short
);

  assign o_is_align     = sym_is(i_win, K28_5_RDN, K28_5_RDP);
  assign o_is_sof_long  = sym_is(i_win, K28_0_RDN, K28_0_RDP);
  assign o_is_sof_short = sym_is(i_win, K28_2_RDN, K28_2_RDP);

endmodule

// File: rtl/rx_align_8b_10b.sv
// 8b/10b receive aligner: acquires symbol lock on K28.5, parses K28.0/K28.2
// start-of-frame symbols and assembles one encoded flit with a done pulse.
// Optional build macro ALIGN_CONFIRM_EN: lock only after two K28.5 commas
// exactly one symbol apart (adds a CONFIRM state between HUNT and IDLE).
module rx_align_8b_10b
  import phy_types_pkg::*;
#(
  parameter int SYM_PER_FLIT = 4
)
(
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          rx_bit,
  input  logic                          rx_valid,
  output logic [SYM_PER_FLIT*SYM_W-1:0] enc_flit,
  output logic                          done,
  output comma_length_sel_t             comma_length_sel,
  output logic                          err,
  output logic                          locked
);

  localparam int FLIT_W = SYM_PER_FLIT * SYM_W;
  localparam int CNT_W  = $clog2(SYM_PER_FLIT + 1);
  localparam logic [CNT_W-1:0] N_LONG  = CNT_W'(SYM_PER_FLIT);
  localparam logic [CNT_W-1:0] N_SHORT = CNT_W'(SYM_PER_FLIT / 2);

  typedef enum logic [1:0] {
    ST_HUNT,
    ST_CONFIRM,
    ST_IDLE,
    ST_COLLECT
  } state_t;

  state_t              r_state;
  logic [8:0]          r_sr;
  logic [3:0]          r_bit_cnt;
  logic [CNT_W-1:0]    r_sym_cnt;
  comma_length_sel_t   r_len;
  logic [FLIT_W-1:0]   r_buf;
  logic [FLIT_W-1:0]   r_enc_flit;
  comma_length_sel_t   r_sel;
  logic                r_done;
  logic                r_err;
  logic                r_locked;

  logic [SYM_W-1:0]    w_win;
  logic                w_is_align;
  logic                w_is_sof_long;
  logic                w_is_sof_short;
  logic                w_boundary;
  logic                w_last;
  logic [FLIT_W-1:0]   w_flit_next;

  assign w_win      = {r_sr, rx_bit};
  assign w_boundary = rx_valid && (r_bit_cnt == 4'd9);
  assign w_last     = (r_sym_cnt + CNT_W'(1)) == ((r_len == LONG) ? N_LONG : N_SHORT);

  rx_sym_match_8b_10b u_match (
    .i_win          (w_win),
    .o_is_align     (w_is_align),
    .o_is_sof_long  (w_is_sof_long),
    .o_is_sof_short (w_is_sof_short)
  );

  // Staging view of the flit with the current window dropped into its slot;
  // short frames zero the upper half so stale long-frame data never leaks out.
  always_comb begin
    w_flit_next = r_buf;
    for (int i = 0; i < SYM_PER_FLIT; i++) begin
      if (CNT_W'(i) == r_sym_cnt) begin
        w_flit_next[i*SYM_W +: SYM_W] = w_win;
      end else if ((r_len == SHORT) && (i >= SYM_PER_FLIT / 2)) begin
        w_flit_next[i*SYM_W +: SYM_W] = '0;
      end
    end
  end

  // Bit shift register and partial-frame buffer (pure data, no reset).
  always_ff @(posedge clk) begin
    if (rx_valid) begin
      r_sr <= w_win[8:0];
      if ((r_state == ST_COLLECT) && w_boundary &&
          !w_is_align && !w_is_sof_long && !w_is_sof_short) begin
        r_buf <= w_flit_next;
      end
    end
  end

  // Alignment / framing FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_HUNT;
      r_bit_cnt  <= 4'd0;
      r_sym_cnt  <= '0;
      r_len      <= LONG;
      r_enc_flit <= '0;
      r_sel      <= LONG;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_locked   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      if (rx_valid) begin
        r_bit_cnt <= w_boundary ? 4'd0 : r_bit_cnt + 4'd1;
        unique case (r_state)
          ST_HUNT: begin
            if (w_is_align) begin
              r_bit_cnt <= 4'd0;
`ifdef ALIGN_CONFIRM_EN
              r_state   <= ST_CONFIRM;
              r_locked  <= 1'b0;
`else
              r_state   <= ST_IDLE;
              r_locked  <= 1'b1;
`endif
            end
          end
`ifdef ALIGN_CONFIRM_EN
          ST_CONFIRM: begin
            // A comma in a new phase restarts the confirmation window.
            if (w_is_align && !w_boundary) begin
              r_bit_cnt <= 4'd0;
            end else if (w_boundary) begin
              if (w_is_align) begin
                r_state  <= ST_IDLE;
                r_locked <= 1'b1;
              end else begin
                r_state  <= ST_HUNT;
                r_locked <= 1'b0;
              end
            end
          end
`endif
          ST_IDLE, ST_COLLECT: begin
            if (w_is_align && !w_boundary) begin
              // Comma off the symbol grid: flag it and relock on this bit.
              r_err     <= 1'b1;
              r_bit_cnt <= 4'd0;
`ifdef ALIGN_CONFIRM_EN
              r_state   <= ST_CONFIRM;
              r_locked  <= 1'b0;
`else
              r_state   <= ST_IDLE;
              r_locked  <= 1'b1;
`endif
            end else if (w_boundary) begin
              if (r_state == ST_IDLE) begin
                if (w_is_sof_long || w_is_sof_short) begin
                  r_len     <= w_is_sof_long ? LONG : SHORT;
                  r_sym_cnt <= '0;
                  r_state   <= ST_COLLECT;
                end
              end else if (w_is_align) begin
                r_err   <= 1'b1;
                r_state <= ST_IDLE;
              end else if (w_is_sof_long || w_is_sof_short) begin
                r_err     <= 1'b1;
                r_len     <= w_is_sof_long ? LONG : SHORT;
                r_sym_cnt <= '0;
              end else if (w_last) begin
                r_enc_flit <= w_flit_next;
                r_sel      <= r_len;
                r_done     <= 1'b1;
                r_state    <= ST_IDLE;
              end else begin
                r_sym_cnt <= r_sym_cnt + CNT_W'(1);
              end
            end
          end
          default: begin
            r_state  <= ST_HUNT;
            r_locked <= 1'b0;
          end
        endcase
      end
    end
  end

  assign enc_flit         = r_enc_flit;
  assign comma_length_sel = r_sel;
  assign done             = r_done;
  assign err              = r_err;
  assign locked           = r_locked;

endmodule

// File: tb/tb_rx_align_8b_10b.sv
// Directed bench for rx_align_8b_10b: lock, long/short frames, abort,
// misalignment relock, rx_valid gaps, reset dominance, optional confirm.
module tb_rx_align_8b_10b;
  import phy_types_pkg::*;

  localparam int SPF = 4;
`ifdef ALIGN_CONFIRM_EN
  localparam logic CONF = 1'b1;
`else
  localparam logic CONF = 1'b0;
`endif

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  rx_bit;
  logic                  rx_valid;
  logic [SPF*SYM_W-1:0]  enc_flit;
  logic                  done;
  comma_length_sel_t     comma_length_sel;
  logic                  err;
  logic                  locked;

  int checks = 0;
  int errors = 0;
  int n_done = 0;
  int n_err  = 0;
  int n_both = 0;
  int d0, e0;
  logic [SPF*SYM_W-1:0]  flit_hold;
  logic [19:0]           noise;

  always #5 clk = ~clk;

  rx_align_8b_10b #(.SYM_PER_FLIT(SPF)) dut (
    .clk              (clk),
    .rst              (rst),
    .rx_bit           (rx_bit),
    .rx_valid         (rx_valid),
    .enc_flit         (enc_flit),
    .done             (done),
    .comma_length_sel (comma_length_sel),
    .err              (err),
    .locked           (locked)
  );

  always @(negedge clk) begin
    if (done) n_done++;
    if (err) n_err++;
    if (done && err) n_both++;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    @(negedge clk); #1;
    rx_bit   = b;
    rx_valid = 1'b1;
  endtask

  task automatic send_part(input logic [9:0] v, input int hi, input int lo);
    for (int i = hi; i >= lo; i--) send_bit(v[i]);
  endtask

  task automatic send_sym(input logic [9:0] v);
    send_part(v, 9, 0);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk); #1;
      rx_valid = 1'b0;
    end
  endtask

  initial begin
    rst = 1'b1; rx_valid = 1'b0; rx_bit = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_locked", locked, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_flit", enc_flit, 0);
    check("rst_sel", comma_length_sel, LONG);
    rst = 1'b0;

    // Noise without commas: no lock, no pulses
    noise = 20'hB3A5C;
    for (int i = 19; i >= 0; i--) begin
      send_bit(noise[i]);
      check("noise_locked", locked, 0);
    end
    idle(1);
    check("noise_locked_end", locked, 0);
    check("noise_no_done", n_done, 0);
    check("noise_no_err", n_err, 0);

    // Lock, then long frame
    send_sym(K28_5_RDN); idle(1);
    check("lock_first", locked, !CONF);
    send_sym(K28_5_RDN); idle(1);
    check("lock_second", locked, 1);
    d0 = n_done; e0 = n_err;
    send_sym(K28_0_RDN);
    send_sym(10'h2AA); send_sym(10'h155); send_sym(10'h0F3);
    check("long_no_early_done", n_done, d0);
    send_sym(10'h30C);
    idle(1);
    check("long_done", done, 1);
    check("long_done_cnt", n_done, d0 + 1);
    check("long_flit", enc_flit, {10'h30C, 10'h0F3, 10'h155, 10'h2AA});
    check("long_sel", comma_length_sel, LONG);
    check("long_no_err", n_err, e0);
    idle(1);
    check("long_done_pulse", done, 0);

    // Short frame, RDP start-of-frame
    d0 = n_done;
    send_sym(K28_2_RDP); send_sym(10'h2AA);
    check("short_flit_hold", enc_flit, {10'h30C, 10'h0F3, 10'h155, 10'h2AA});
    send_sym(10'h155);
    idle(1);
    check("short_done", done, 1);
    check("short_done_cnt", n_done, d0 + 1);
    check("short_flit", enc_flit, {10'h000, 10'h000, 10'h155, 10'h2AA});
    check("short_sel", comma_length_sel, SHORT);

    // Comma aborts a partial frame, next frame completes
    d0 = n_done; e0 = n_err;
    send_sym(K28_0_RDN); send_sym(10'h2AA); send_sym(10'h155);
    send_sym(K28_5_RDN);
    idle(1);
    check("abort_err", err, 1);
    check("abort_err_cnt", n_err, e0 + 1);
    check("abort_no_done", n_done, d0);
    check("abort_flit_hold", enc_flit, {10'h000, 10'h000, 10'h155, 10'h2AA});
    send_sym(K28_0_RDN);
    send_sym(10'h155); send_sym(10'h2AA); send_sym(10'h30C); send_sym(10'h0F3);
    idle(1);
    check("after_abort_done", done, 1);
    check("after_abort_flit", enc_flit, {10'h0F3, 10'h30C, 10'h2AA, 10'h155});
    check("after_abort_sel", comma_length_sel, LONG);

    // Phase slip of 3 bits, comma completes off grid
    d0 = n_done; e0 = n_err;
    send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
    send_sym(K28_5_RDN);
    idle(1);
    check("slip_err", err, 1);
    check("slip_err_cnt", n_err, e0 + 1);
    check("slip_locked", locked, !CONF);
    check("slip_no_done", n_done, d0);
    send_sym(K28_5_RDN);
    send_sym(K28_0_RDN);
    send_sym(10'h2AA); send_sym(10'h2AA); send_sym(10'h155); send_sym(10'h155);
    idle(1);
    check("slip_frame_done", done, 1);
    check("slip_frame_flit", enc_flit, {10'h155, 10'h155, 10'h2AA, 10'h2AA});
    check("slip_frame_locked", locked, 1);

    // rx_valid gap mid-symbol
    d0 = n_done;
    flit_hold = enc_flit;
    send_sym(K28_0_RDN); send_sym(10'h2AA); send_sym(10'h155);
    send_part(10'h0F3, 9, 5);
    idle(5);
    check("gap_no_done", n_done, d0);
    check("gap_flit_hold", enc_flit, flit_hold);
    check("gap_locked", locked, 1);
    send_part(10'h0F3, 4, 0);
    send_sym(10'h30C);
    idle(1);
    check("gap_done", done, 1);
    check("gap_flit", enc_flit, {10'h30C, 10'h0F3, 10'h155, 10'h2AA});

    // Short frame, then reset mid-collect of the next one
    send_sym(K28_2_RDN); send_sym(10'h155); send_sym(10'h2AA);
    idle(1);
    check("pre_rst_sel", comma_length_sel, SHORT);
    check("pre_rst_flit", enc_flit, {10'h000, 10'h000, 10'h2AA, 10'h155});
    send_sym(K28_2_RDN); send_sym(10'h2AA);
    @(negedge clk); #1;
    rst = 1'b1; rx_valid = 1'b1; rx_bit = 1'b1;
    @(negedge clk); #1;
    rst = 1'b0; rx_valid = 1'b0;
    check("mid_rst_locked", locked, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_err", err, 0);
    check("mid_rst_flit", enc_flit, 0);
    check("mid_rst_sel", comma_length_sel, LONG);

    // Single comma followed by data, then two commas
    e0 = n_err;
    send_sym(K28_5_RDN); send_sym(10'h2AA);
    idle(1);
    check("single_comma_locked", locked, !CONF);
    check("single_comma_no_err", n_err, e0);
    send_sym(K28_5_RDN); send_sym(K28_5_RDN);
    idle(1);
    check("double_comma_locked", locked, 1);

    check("never_done_and_err", n_both, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
